// File: rtl/pupil_pkg.sv
// rtl/pupil_pkg.sv - shared FSM encoding and default geometry for the pupil bounding-box locator
package pupil_pkg;

    localparam int GREY_W    = 10;
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_coord_counter.sv
// rtl/pixel_coord_counter.sv - raster x/y counter: clear, advance per pixel, wrap at line end, stop below the frame
module pixel_coord_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCLR,
    input  logic          iINC,
    output logic [XW-1:0] oX,
    output logic [YW-1:0] oY,
    output logic          oROWOK
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    // Row counter is one bit wider so it can park at IMG_H even when IMG_H is a power of two.
    localparam logic [YW:0]   Y_END  = (YW + 1)'(IMG_H);

    logic [XW-1:0] xCnt;
    logic [YW:0]   yCnt;

    // Advance column per pixel; at line end wrap column and step row until it parks at IMG_H.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (iCLR) begin
            xCnt <= '0;
            yCnt <= '0;
        end else if (iINC) begin
            if (xCnt == X_LAST) begin
                xCnt <= '0;
                if (yCnt != Y_END) begin
                    yCnt <= yCnt + {{YW{1'b0}}, 1'b1};
                end
            end else begin
                xCnt <= xCnt + {{(XW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign oX     = xCnt;
    assign oY     = yCnt[YW-1:0];
    assign oROWOK = (yCnt < Y_END);

endmodule

// File: rtl/pupil_bbox_locator.sv
// rtl/pupil_bbox_locator.sv - dark-pixel bounding box, centre and count per frame; PUPIL_MASK_OUT_EN adds oMASK/oMVAL
module pupil_bbox_locator
    import pupil_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int CW    = 19
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iFVAL,
    input  logic              iDVAL,
    input  logic [GREY_W-1:0] iDATA,
    input  logic [GREY_W-1:0] iTHRESH,
    output logic              oRVAL,
    output logic              oFOUND,
    output logic [XW-1:0]     oXMIN,
    output logic [XW-1:0]     oXMAX,
    output logic [YW-1:0]     oYMIN,
    output logic [YW-1:0]     oYMAX,
    output logic [XW-1:0]     oXC,
    output logic [YW-1:0]     oYC,
`ifdef PUPIL_MASK_OUT_EN
    output logic              oMASK,
    output logic              oMVAL,
`endif
    output logic [CW-1:0]     oCOUNT
);

    state_t              state;
    logic                fvalR, fvalPrev, dvalR;
    logic [GREY_W-1:0]   dataR, thresh;
    logic [XW-1:0]       xMin, xMax, pixX;
    logic [YW-1:0]       yMin, yMax, pixY;
    logic [CW-1:0]       count;
    logic                rowOk, dark, frameRise, cntClr, cntInc;
    logic [XW:0]         xSum;
    logic [YW:0]         ySum;

    assign frameRise = fvalR & ~fvalPrev;
    assign dark      = (dataR < thresh);
    assign cntClr    = (state == ST_IDLE) & frameRise;
    assign cntInc    = (state == ST_ACCUM) & fvalR & dvalR;
    assign xSum      = {1'b0, xMin} + {1'b0, xMax};
    assign ySum      = {1'b0, yMin} + {1'b0, yMax};

    pixel_coord_counter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW)
    ) u_coord (
        .iCLK(iCLK), .iRST(iRST), .iCLR(cntClr), .iINC(cntInc),
        .oX(pixX), .oY(pixY), .oROWOK(rowOk)
    );

    // Input stage; frame-valid history resets high so a frame already running at reset release is not taken as a start.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            fvalR    <= 1'b1;
            fvalPrev <= 1'b1;
            dvalR    <= 1'b0;
            dataR    <= '0;
        end else begin
            fvalR    <= iFVAL;
            fvalPrev <= fvalR;
            dvalR    <= iDVAL;
            dataR    <= iDATA;
        end
    end

    // Frame FSM: arm on rise, accumulate box and count, publish results for one strobe cycle on fall.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state  <= ST_IDLE;
            thresh <= '0;
            xMin   <= '0;
            xMax   <= '0;
            yMin   <= '0;
            yMax   <= '0;
            count  <= '0;
            oRVAL  <= 1'b0;
            oFOUND <= 1'b0;
            oXMIN  <= '0;
            oXMAX  <= '0;
            oYMIN  <= '0;
            oYMAX  <= '0;
            oXC    <= '0;
            oYC    <= '0;
            oCOUNT <= '0;
        end else begin
            oRVAL <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frameRise) begin
                        thresh <= iTHRESH;
                        xMin   <= '1;
                        xMax   <= '0;
                        yMin   <= '1;
                        yMax   <= '0;
                        count  <= '0;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (!fvalR) begin
                        state <= ST_REPORT;
                    end else if (dvalR && dark && rowOk) begin
                        if (pixX < xMin) xMin <= pixX;
                        if (pixX > xMax) xMax <= pixX;
                        if (pixY < yMin) yMin <= pixY;
                        if (pixY > yMax) yMax <= pixY;
                        if (count != '1) count <= count + CW'(1);
                    end
                end
                ST_REPORT: begin
                    oRVAL  <= 1'b1;
                    oCOUNT <= count;
                    if (count != '0) begin
                        oFOUND <= 1'b1;
                        oXMIN  <= xMin;
                        oXMAX  <= xMax;
                        oYMIN  <= yMin;
                        oYMAX  <= yMax;
                        oXC    <= xSum[XW:1];
                        oYC    <= ySum[YW:1];
                    end else begin
                        oFOUND <= 1'b0;
                        oXMIN  <= '0;
                        oXMAX  <= '0;
                        oYMIN  <= '0;
                        oYMAX  <= '0;
                        oXC    <= '0;
                        oYC    <= '0;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PUPIL_MASK_OUT_EN
    // Per-pixel dark flag for the display overlay, aligned two cycles after iDVAL.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oMASK <= 1'b0;
            oMVAL <= 1'b0;
        end else begin
            oMASK <= dark;
            oMVAL <= dvalR && (state == ST_ACCUM);
        end
    end
`endif

endmodule

// File: tb/tb_pupil_bbox_locator.sv
// tb/tb_pupil_bbox_locator.sv - self-checking bench for pupil_bbox_locator against a frame-level reference model
module tb_pupil_bbox_locator;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int XW    = 3;
    localparam int YW    = 2;
    localparam int CW    = 6;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b0;
    logic          iFVAL = 1'b0;
    logic          iDVAL = 1'b0;
    logic [9:0]    iDATA = '0;
    logic [9:0]    iTHRESH = '0;
    logic          oRVAL, oFOUND;
    logic [XW-1:0] oXMIN, oXMAX, oXC;
    logic [YW-1:0] oYMIN, oYMAX, oYC;
    logic [CW-1:0] oCOUNT;

    int vectors = 0;
    int miscompares = 0;
    int rvalCnt = 0;
    int frame[$];
    int eFound, eXmin, eXmax, eYmin, eYmax, eXc, eYc, eCount;

    pupil_bbox_locator #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW), .CW(CW)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
        .iDATA(iDATA), .iTHRESH(iTHRESH), .oRVAL(oRVAL), .oFOUND(oFOUND),
        .oXMIN(oXMIN), .oXMAX(oXMAX), .oYMIN(oYMIN), .oYMAX(oYMAX),
        .oXC(oXC), .oYC(oYC), .oCOUNT(oCOUNT)
    );

    always #5 iCLK = ~iCLK;

    always @(negedge iCLK) if (oRVAL === 1'b1) rvalCnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Frame-level reference: pixel i of the frame sits at column i%IMG_W, row i/IMG_W.
    task automatic model(input int thr);
        int cnt, xmn, xmx, ymn, ymx;
        cnt = 0; xmn = 0; xmx = 0; ymn = 0; ymx = 0;
        for (int i = 0; i < frame.size(); i++) begin
            int x, y;
            x = i % IMG_W;
            y = i / IMG_W;
            if (y < IMG_H && frame[i] < thr) begin
                if (cnt == 0) begin
                    xmn = x; xmx = x; ymn = y; ymx = y;
                end else begin
                    xmn = (x < xmn) ? x : xmn;
                    xmx = (x > xmx) ? x : xmx;
                    ymn = (y < ymn) ? y : ymn;
                    ymx = (y > ymx) ? y : ymx;
                end
                cnt++;
            end
        end
        eCount = (cnt > (1 << CW) - 1) ? (1 << CW) - 1 : cnt;
        eFound = (cnt != 0);
        eXmin = (cnt != 0) ? xmn : 0;
        eXmax = (cnt != 0) ? xmx : 0;
        eYmin = (cnt != 0) ? ymn : 0;
        eYmax = (cnt != 0) ? ymx : 0;
        eXc   = (cnt != 0) ? (xmn + xmx) / 2 : 0;
        eYc   = (cnt != 0) ? (ymn + ymx) / 2 : 0;
    endtask

    task automatic check_report(input string p);
        check({p, "_found"}, oFOUND, eFound);
        check({p, "_xmin"},  oXMIN,  eXmin);
        check({p, "_xmax"},  oXMAX,  eXmax);
        check({p, "_ymin"},  oYMIN,  eYmin);
        check({p, "_ymax"},  oYMAX,  eYmax);
        check({p, "_xc"},    oXC,    eXc);
        check({p, "_yc"},    oYC,    eYc);
        check({p, "_count"}, oCOUNT, eCount);
    endtask

    // Play the queued frame with random gaps, then verify strobe timing and the reported result.
    task automatic run_frame(input string p, input int thr, input int maxGap, input bit tailDark);
        int r0;
        iTHRESH = 10'(thr);
        iFVAL = 1'b1;
        iDVAL = 1'b0;
        tick();
        tick();
        foreach (frame[i]) begin
            repeat ($urandom_range(maxGap, 0)) begin
                iDVAL = 1'b0;
                iDATA = 10'($urandom_range(1023, 0));
                iTHRESH = 10'($urandom_range(1023, 0));
                tick();
            end
            iDVAL = 1'b1;
            iDATA = 10'(frame[i]);
            iTHRESH = 10'($urandom_range(1023, 0));
            tick();
        end
        r0 = rvalCnt;
        iFVAL = 1'b0;
        iDVAL = tailDark;
        iDATA = '0;
        tick();
        iDVAL = 1'b0;
        tick();
        check({p, "_rval_early"}, oRVAL, 0);
        tick();
        check({p, "_rval_pulse"}, oRVAL, 1);
        model(thr);
        check_report(p);
        tick();
        check({p, "_rval_drop"}, oRVAL, 0);
        check({p, "_rval_once"}, rvalCnt - r0, 1);
        repeat (4) begin
            iDVAL = 1'(($urandom_range(1, 0)));
            iDATA = '0;
            tick();
        end
        iDVAL = 1'b0;
        check_report({p, "_hold"});
    endtask

    initial begin
        int r0;

        // Reset state, then idle with no frame.
        iRST = 1'b0;
        tick();
        tick();
        frame.delete();
        model(0);
        check_report("rst");
        check("rst_rval", oRVAL, 0);
        iRST = 1'b1;
        repeat (10) tick();
        check_report("idle");
        check("idle_rval_cnt", rvalCnt, 0);

        // Bright frame: nothing below threshold.
        frame.delete();
        repeat (32) frame.push_back(1023);
        run_frame("bright", 100, 2, 1'b0);

        // Three dark pixels at (2,1),(5,1),(3,2).
        frame.delete();
        repeat (32) frame.push_back(900);
        frame[1*8+2] = 0;
        frame[1*8+5] = 0;
        frame[2*8+3] = 0;
        run_frame("dark3", 100, 1, 1'b0);
        check("dark3_xmin_c", oXMIN, 2);
        check("dark3_xmax_c", oXMAX, 5);
        check("dark3_ymin_c", oYMIN, 1);
        check("dark3_ymax_c", oYMAX, 2);
        check("dark3_xc_c", oXC, 3);
        check("dark3_yc_c", oYC, 1);
        check("dark3_count_c", oCOUNT, 3);

        // Threshold is strict: equal is bright, one below is dark.
        frame.delete();
        repeat (16) frame.push_back(900);
        frame[3] = 100;
        frame[6] = 99;
        run_frame("thresh", 100, 1, 1'b0);
        check("thresh_count_c", oCOUNT, 1);
        check("thresh_xmin_c", oXMIN, 6);

        // Whole frame dark plus pixels past the last row.
        frame.delete();
        repeat (72) frame.push_back(0);
        run_frame("overrun", 100, 0, 1'b0);
        check("overrun_count_c", oCOUNT, 32);
        check("overrun_ymax_c", oYMAX, 3);

        // Early fall after 12 pixels, with a dark pixel alongside the fall.
        frame.delete();
        repeat (12) frame.push_back(0);
        run_frame("part", 100, 1, 1'b1);
        check("part_xmax_c", oXMAX, 7);
        check("part_ymax_c", oYMAX, 1);
        check("part_count_c", oCOUNT, 12);

        // Reset in the middle of the next frame: no strobe, outputs cleared, frame discarded.
        r0 = rvalCnt;
        iTHRESH = 10'd100;
        iFVAL = 1'b1;
        tick();
        tick();
        repeat (5) begin
            iDVAL = 1'b1;
            iDATA = '0;
            tick();
        end
        iRST = 1'b0;
        #1;
        frame.delete();
        model(0);
        check_report("rstmid");
        check("rstmid_rval", oRVAL, 0);
        tick();
        iRST = 1'b1;
        repeat (6) tick();
        iFVAL = 1'b0;
        iDVAL = 1'b0;
        repeat (8) tick();
        check("rstmid_no_rval", rvalCnt - r0, 0);
        check_report("rstmid_after");

        // Randomized frames.
        for (int f = 0; f < 6; f++) begin
            int thr, len;
            thr = $urandom_range(1023, 0);
            len = $urandom_range(45, 0);
            frame.delete();
            for (int i = 0; i < len; i++) frame.push_back($urandom_range(1023, 0));
            run_frame($sformatf("rnd%0d", f), thr, 2, 1'($urandom_range(1, 0)));
            repeat (3) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
